// File: rtl/fifo_pkg.sv
// Shared defaults and types for the single-clock FIFO.
package fifo_pkg;

    localparam int unsigned FIFO_DATA_W = 8;
    localparam int unsigned FIFO_DEPTH  = 8;
    localparam int unsigned FIFO_ADDR_W = $clog2(FIFO_DEPTH);

    // Accepted operation in a cycle, encoded as {read, write}.
    typedef enum logic [1:0] {
        OpNone  = 2'b00,
        OpWrite = 2'b01,
        OpRead  = 2'b10,
        OpBoth  = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: one write port, one registered read port, no reset.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = FIFO_DATA_W,
    parameter int unsigned DEPTH  = FIFO_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // A same-edge read of the written slot returns the old (oldest) entry.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo.sv
// Single-clock FIFO: pointers, occupancy count and flags around fifo_ram.
module fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = FIFO_DATA_W,
    parameter int unsigned DEPTH  = FIFO_DEPTH
) (
    input  logic [DATA_W-1:0] in,
    input  logic              rst,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic              clk,
    output logic              empty,
    output logic              full,
    output logic [DATA_W-1:0] out
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty_q, full_q;
    logic              hold_zero_q;
    logic              rd_acc, wr_acc;
    fifo_op_e          op;
    logic [DATA_W-1:0] rdata;

    always_comb begin
        rd_acc  = rd_en && !empty_q;
        wr_acc  = wr_en && (!full_q || rd_acc);
        op      = fifo_op_e'({rd_acc, wr_acc});
        wptr_d  = wr_acc ? wptr_q + ADDR_W'(1) : wptr_q;
        rptr_d  = rd_acc ? rptr_q + ADDR_W'(1) : rptr_q;
        count_d = count_q;
        unique case (op)
            OpWrite: count_d = count_q + CNT_W'(1);
            OpRead:  count_d = count_q - CNT_W'(1);
            OpNone,
            OpBoth:  count_d = count_q;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            hold_zero_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CNT_W'(DEPTH));
            if (rd_acc) begin
                hold_zero_q <= 1'b0;
            end
        end
    end

    fifo_ram #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (wr_acc && !rst),
        .waddr(wptr_q),
        .wdata(in),
        .re   (rd_acc && !rst),
        .raddr(rptr_q),
        .rdata(rdata)
    );

    // The RAM read register has no reset; out reads as zero until the first read after reset.
    assign empty = empty_q;
    assign full  = full_q;
    assign out   = hold_zero_q ? '0 : rdata;

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo against a queue-based reference model.
module tb_fifo;

    localparam int DW = 8;
    localparam int DP = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_en = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] din = '0;
    logic          empty, full;
    logic [DW-1:0] dout;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_out = '0;

    fifo #(.DATA_W(DW), .DEPTH(DP)) dut (
        .in   (din),
        .rst  (rst),
        .rd_en(rd_en),
        .wr_en(wr_en),
        .clk  (clk),
        .empty(empty),
        .full (full),
        .out  (dout)
    );

    always #5 clk = ~clk;

    // Drive one cycle, advance the reference model, then settle past the edge.
    task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d, input logic rs);
        bit rd_ok, wr_ok;
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        din   = d;
        rst   = rs;
        @(posedge clk);
        if (rs) begin
            mq.delete();
            m_out = '0;
        end else begin
            rd_ok = r && (mq.size() > 0);
            wr_ok = w && ((mq.size() < DP) || rd_ok);
            if (rd_ok) m_out = mq.pop_front();
            if (wr_ok) mq.push_back(d);
        end
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b0, '0, 1'b1);
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b want=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b want=0", full); end
        checks++; if (dout !== 8'd0) begin failures++; $display("FAIL reset_out got=%0d want=0", dout); end
    endtask

    task automatic test_basic();
        for (int i = 1; i <= 3; i++) cycle(1'b1, 1'b0, DW'(i), 1'b0);
        checks++; if (empty !== 1'b0) begin failures++; $display("FAIL basic_empty_after_wr got=%b want=0", empty); end
        cycle(1'b0, 1'b1, '0, 1'b0);
        checks++; if (dout !== 8'd1) begin failures++; $display("FAIL basic_rd1 got=%0d want=1", dout); end
        cycle(1'b0, 1'b1, '0, 1'b0);
        checks++; if (dout !== 8'd2) begin failures++; $display("FAIL basic_rd2 got=%0d want=2", dout); end
        checks++; if (empty !== 1'b0) begin failures++; $display("FAIL basic_one_left got=%b want=0", empty); end
        cycle(1'b0, 1'b0, '0, 1'b0);
        checks++; if (dout !== 8'd2) begin failures++; $display("FAIL basic_hold got=%0d want=2", dout); end
        cycle(1'b0, 1'b1, '0, 1'b0);
        checks++; if (dout !== 8'd3) begin failures++; $display("FAIL basic_rd3 got=%0d want=3", dout); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL basic_drained got=%b want=1", empty); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, DW'(10 + i), 1'b0);
            if (i == 6) begin
                checks++; if (full !== 1'b0) begin failures++; $display("FAIL fill_not_full_at7 got=%b want=0", full); end
            end
        end
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b want=1", full); end
        cycle(1'b1, 1'b0, 8'd99, 1'b0);
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_overflow_full got=%b want=1", full); end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, '0, 1'b0);
            checks++;
            if (dout !== DW'(10 + i)) begin
                failures++; $display("FAIL fill_rd%0d got=%0d want=%0d", i, dout, 10 + i);
            end
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL fill_empty got=%b want=1", empty); end
    endtask

    task automatic test_edges();
        logic [DW-1:0] first;
        cycle(1'b0, 1'b1, '0, 1'b0);
        checks++; if (dout !== 8'd17) begin failures++; $display("FAIL empty_rd_out got=%0d want=17", dout); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL empty_rd_flag got=%b want=1", empty); end
        // Simultaneous read and write while empty: write only.
        cycle(1'b1, 1'b1, 8'd42, 1'b0);
        checks++; if (dout !== 8'd17) begin failures++; $display("FAIL empty_rw_out got=%0d want=17", dout); end
        checks++; if (empty !== 1'b0) begin failures++; $display("FAIL empty_rw_flag got=%b want=0", empty); end
        cycle(1'b0, 1'b1, '0, 1'b0);
        checks++; if (dout !== 8'd42) begin failures++; $display("FAIL empty_rw_data got=%0d want=42", dout); end
        first = DW'($urandom_range(0, 255));
        cycle(1'b1, 1'b0, first, 1'b0);
        for (int i = 1; i < 8; i++) cycle(1'b1, 1'b0, DW'($urandom), 1'b0);
        cycle(1'b1, 1'b1, 8'd55, 1'b0);
        checks++; if (dout !== first) begin failures++; $display("FAIL full_rw_out got=%0d want=%0d", dout, first); end
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_rw_full got=%b want=1", full); end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, '0, 1'b0);
            checks++;
            if (dout !== m_out) begin
                failures++; $display("FAIL full_rw_drain%0d got=%0d want=%0d", i, dout, m_out);
            end
        end
        checks++; if (dout !== 8'd55) begin failures++; $display("FAIL full_rw_last got=%0d want=55", dout); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL full_rw_empty got=%b want=1", empty); end
    endtask

    task automatic test_wrap();
        cycle(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, DW'($urandom), 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, '0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, DW'(20 + i), 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, '0, 1'b0);
            checks++;
            if (dout !== DW'(20 + i)) begin
                failures++; $display("FAIL wrap_rd%0d got=%0d want=%0d", i, dout, 20 + i);
            end
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL wrap_empty got=%b want=1", empty); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, DW'(70 + i), 1'b0);
        cycle(1'b0, 1'b1, '0, 1'b0);
        checks++; if (dout !== 8'd70) begin failures++; $display("FAIL rstmid_pre got=%0d want=70", dout); end
        cycle(1'b1, 1'b1, 8'd5, 1'b1);
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rstmid_empty got=%b want=1", empty); end
        checks++; if (dout !== 8'd0) begin failures++; $display("FAIL rstmid_out got=%0d want=0", dout); end
        cycle(1'b0, 1'b1, '0, 1'b0);
        checks++; if (dout !== 8'd0) begin failures++; $display("FAIL rstmid_rd_out got=%0d want=0", dout); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rstmid_rd_empty got=%b want=1", empty); end
    endtask

    task automatic test_random();
        logic w, r, rs;
        for (int n = 0; n < 400; n++) begin
            w  = ($urandom_range(0, 99) < 55);
            r  = ($urandom_range(0, 99) < 45);
            rs = ($urandom_range(0, 99) == 0);
            cycle(w, r, DW'($urandom), rs);
            checks++;
            if (dout !== m_out || empty !== (mq.size() == 0) || full !== (mq.size() == DP)) begin
                failures++;
                $display("FAIL random_%0d got out=%0d empty=%b full=%b want out=%0d empty=%b full=%b",
                         n, dout, empty, full, m_out, mq.size() == 0, mq.size() == DP);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_edges();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
